cpu_fetch_unit: RTL and testbench

//   Instruction fetch stage: owns the fetch PC and issues requests to instruction memory.

---
 rtl/cpu_fetch_unit_if.sv | 27 ++
 rtl/cpu_fetch_unit.sv | 111 +++++++++++
 tb/tb_cpu_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus the
// fetch->decode instruction interface and the decode-side controls (stall, redirect).
//   master : the fetch unit (drives imem_req_o/imem_addr_o and valid_f_o/inst_f_o/pc_f_o)
//   slave  : memory + decode side (drives gnt/rvalid/rdata, stall, redirect)
interface cpu_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_f_o;
  logic [31:0] inst_f_o;
  logic [31:0] pc_f_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_f_o, inst_f_o, pc_f_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_f_o, inst_f_o, pc_f_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, stall_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage. Owns the fetch PC, issues word requests to instruction
// memory, buffers in-order responses in a small queue and presents the head to the
// IF/ID register. Redirects flush the queue and discard responses still in flight.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : cpu_fetch_unit_if.master (imem request/response, stall/redirect, inst/pc out)
module cpu_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cpu_fetch_unit_if.master  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      pc;
  logic [31:0]      inst_mem [FIFO_DEPTH];
  logic [31:0]      pcq_mem  [FIFO_DEPTH];
  logic [31:0]      tag_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0] q_wr, q_rd, tag_wr, tag_rd;
  logic [CNT_W-1:0] q_count, outstanding, drop_cnt;

  logic             issue, grant, resp, drop, push, pop, valid;
  logic [CNT_W-1:0] outstanding_nxt;

  // Handshake decode. Each in-flight request holds a queue slot, so push never overflows.
  always_comb begin
    issue = 1'b0;
    grant = 1'b0;
    resp  = 1'b0;
    drop  = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    valid = 1'b0;
    issue = !rst_i && !bus.redirect_i &&
            ((SUM_W'(q_count) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH));
    grant = issue && bus.imem_gnt_i;
    resp  = bus.imem_rvalid_i && (outstanding != '0);
    // A response in the redirect cycle belongs to the old stream and is discarded too.
    drop  = resp && (bus.redirect_i || (drop_cnt != '0));
    push  = resp && !drop;
    valid = (q_count != '0) && !bus.redirect_i;
    pop   = valid && !bus.stall_i;
    outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(resp);
  end

  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = pc;
  assign bus.valid_f_o   = valid;
  assign bus.inst_f_o    = valid ? inst_mem[q_rd] : 32'h0;
  assign bus.pc_f_o      = valid ? pcq_mem[q_rd]  : 32'h0;

  // Control state: pc, pointers and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc          <= RESET_PC;
      q_wr        <= '0;
      q_rd        <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      q_count     <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_i) begin
        // Everything still in flight after this cycle belongs to the old stream.
        pc       <= bus.redirect_pc_i;
        q_wr     <= '0;
        q_rd     <= '0;
        tag_wr   <= '0;
        tag_rd   <= '0;
        q_count  <= '0;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (grant) begin
          pc     <= pc + 32'd4;
          tag_wr <= tag_wr + PTR_W'(1);
        end
        if (push) begin
          q_wr   <= q_wr + PTR_W'(1);
          tag_rd <= tag_rd + PTR_W'(1);
        end
        if (drop) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
        if (pop) begin
          q_rd <= q_rd + PTR_W'(1);
        end
        q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Payload storage: request-pc tags and the instruction queue.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      tag_mem[tag_wr] <= pc;
    end
    if (push) begin
      inst_mem[q_wr] <= bus.imem_rdata_i;
      pcq_mem[q_wr]  <= tag_mem[tag_rd];
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Testbench for cpu_fetch_unit: memory responder with random in-order latency, a
// reference model of the delivered instruction stream, and directed plus random phases.
module tb_cpu_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned FIFO_DEPTH = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  cpu_fetch_unit_if bus();

  cpu_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] addr; int ready; } req_t;

  exp_t        exp_q[$];   // words decode must receive, in order
  req_t        pend_q[$];  // requests accepted by the memory, not yet answered
  logic [31:0] model_pc;
  int          checks = 0, failures = 0;
  int          cyc = 0, grants = 0, pops = 0;
  int          lat_min = 1, lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Start a cycle: past the rising edge, drive the memory response for this cycle.
  task automatic begin_cycle();
    @(posedge clk_i);
    #1;
    cyc++;
    if (!rst_i && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mem_word(pend_q[0].addr);
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom;
    end
  endtask

  task automatic drive(input bit g, input bit s, input bit r, input logic [31:0] rpc);
    bus.imem_gnt_i    = g;
    bus.stall_i       = s;
    bus.redirect_i    = r;
    bus.redirect_pc_i = rpc;
  endtask

  task automatic cycle(input bit g, input bit s, input bit r, input logic [31:0] rpc);
    begin_cycle();
    drive(g, s, r, rpc);
  endtask

  task automatic settle();
    @(negedge clk_i);
    #1;
  endtask

  // Redirect with no grants, then wait for all old responses to come back.
  task automatic quiesce(input logic [31:0] new_pc);
    cycle(0, 1, 1, new_pc);
    for (int i = 0; i < 20 && pend_q.size() > 0; i++) cycle(0, 1, 0, 32'h0);
    chk("quiesce_done", 32'(pend_q.size()), 32'd0);
  endtask

  // Monitor / scoreboard: observes each cycle mid-way, after inputs and outputs settle.
  exp_t mon_e;
  int   mon_rdy;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.valid_f_o && !bus.stall_i) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got pc %08h inst %08h, expected no instruction",
                   bus.pc_f_o, bus.inst_f_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_pc", bus.pc_f_o, mon_e.pc);
          chk("out_inst", bus.inst_f_o, mon_e.inst);
        end
      end
      if (!bus.valid_f_o) begin
        chk("idle_inst_zero", bus.inst_f_o, 32'h0);
        chk("idle_pc_zero", bus.pc_f_o, 32'h0);
      end
      if (bus.redirect_i) begin
        chk("redirect_no_valid", 32'(bus.valid_f_o), 32'd0);
        chk("redirect_no_req", 32'(bus.imem_req_o), 32'd0);
      end
      if (bus.imem_req_o) chk("issue_addr", bus.imem_addr_o, model_pc);
      if (bus.imem_rvalid_i && pend_q.size() > 0) void'(pend_q.pop_front());
      if (bus.imem_req_o && bus.imem_gnt_i) begin
        grants++;
        exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc)});
        mon_rdy = cyc + $urandom_range(lat_max, lat_min);
        if (pend_q.size() > 0 && pend_q[$].ready + 1 > mon_rdy) mon_rdy = pend_q[$].ready + 1;
        pend_q.push_back('{addr: model_pc, ready: mon_rdy});
        chk("inflight_limit", 32'(pend_q.size() <= FIFO_DEPTH), 32'd1);
        model_pc = model_pc + 32'd4;
      end
      if (bus.redirect_i) begin
        exp_q.delete();
        model_pc = bus.redirect_pc_i;
      end
    end
  end

  int          start_cyc, first_valid, g0;
  logic [31:0] rnd;
  bit          found;

  initial begin
    rst_i = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    drive(0, 0, 0, 32'h0);
    model_pc = RESET_PC;
    repeat (3) @(posedge clk_i);
    #2;
    chk("reset_req", 32'(bus.imem_req_o), 32'd0);
    chk("reset_valid", 32'(bus.valid_f_o), 32'd0);
    chk("reset_inst", bus.inst_f_o, 32'h0);
    chk("reset_pc", bus.pc_f_o, 32'h0);
    chk("reset_addr", bus.imem_addr_o, RESET_PC);

    // Straight-line fetch, 1-cycle memory, no stall.
    begin_cycle();
    rst_i = 1'b0;
    drive(1, 0, 0, 32'h0);
    start_cyc = cyc;
    first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (bus.valid_f_o && first_valid < 0) begin
        first_valid = cyc;
        chk("first_pc", bus.pc_f_o, RESET_PC);
        chk("first_inst", bus.inst_f_o, mem_word(RESET_PC));
      end
      cycle(1, 0, 0, 32'h0);
    end
    chk("first_latency", 32'(first_valid - start_cyc), 32'd2);

    // Stall from an empty queue: prefetch fills exactly FIFO_DEPTH words.
    quiesce(32'h40);
    g0 = grants;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0, 32'h0);
      settle();
      if (i >= 4) chk("stall_head_pc", bus.pc_f_o, 32'h40);
    end
    chk("stall_grants", 32'(grants - g0), 32'(FIFO_DEPTH));
    chk("stall_valid", 32'(bus.valid_f_o), 32'd1);
    chk("stall_head_inst", bus.inst_f_o, mem_word(32'h40));
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 32'h0);

    // Redirect with two slow responses in flight.
    lat_min = 3;
    lat_max = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1, 0, 0, 32'h0);
      if (pend_q.size() == 2) found = 1;
    end
    chk("two_in_flight", 32'(found), 32'd1);
    cycle(1, 0, 1, 32'h100);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(1, 0, 0, 32'h0);
      settle();
      if (bus.valid_f_o) begin
        found = 1;
        chk("redir_first_pc", bus.pc_f_o, 32'h100);
        chk("redir_first_inst", bus.inst_f_o, mem_word(32'h100));
      end
    end
    chk("redir_output_seen", 32'(found), 32'd1);

    // Redirect colliding with a response and a stall.
    lat_min = 1;
    lat_max = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      begin_cycle();
      if (bus.imem_rvalid_i) begin
        found = 1;
        drive(1, 1, 1, 32'h200);
      end else begin
        drive(1, 0, 0, 32'h0);
      end
    end
    chk("collide_rvalid_seen", 32'(found), 32'd1);
    settle();
    chk("collide_valid", 32'(bus.valid_f_o), 32'd0);
    begin_cycle();
    drive(1, 0, 0, 32'h0);
    #1;
    chk("collide_t1_empty", 32'(bus.valid_f_o), 32'd0);
    chk("collide_t1_addr", bus.imem_addr_o, 32'h200);
    chk("collide_t1_req", 32'(bus.imem_req_o), 32'(pend_q.size() < FIFO_DEPTH));
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 32'h0);

    // Grant withheld: pc holds, then a redirect takes over.
    quiesce(32'h80);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 32'h0);
      settle();
      chk("nogrant_req", 32'(bus.imem_req_o), 32'd1);
      chk("nogrant_addr", bus.imem_addr_o, 32'h80);
    end
    cycle(0, 0, 1, 32'h300);
    begin_cycle();
    drive(0, 0, 0, 32'h0);
    #1;
    chk("nogrant_redir_addr", bus.imem_addr_o, 32'h300);

    // Address wrap at the top of the space.
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 32'h0);
    settle();
    chk("wrap_req", 32'(bus.imem_req_o), 32'd1);
    chk("wrap_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
    begin_cycle();
    drive(0, 0, 0, 32'h0);
    #1;
    chk("wrap_addr_zero", bus.imem_addr_o, 32'h0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 32'h0);

    // Asynchronous reset mid-stream.
    lat_max = 3;
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 32'h0);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    chk("async_rst_req", 32'(bus.imem_req_o), 32'd0);
    chk("async_rst_valid", 32'(bus.valid_f_o), 32'd0);
    chk("async_rst_inst", bus.inst_f_o, 32'h0);
    chk("async_rst_pc", bus.pc_f_o, 32'h0);
    chk("async_rst_addr", bus.imem_addr_o, RESET_PC);
    pend_q.delete();
    exp_q.delete();
    model_pc = RESET_PC;
    bus.imem_rvalid_i = 1'b0;
    repeat (2) begin_cycle();
    rst_i = 1'b0;
    drive(1, 0, 0, 32'h0);
    settle();
    chk("post_rst_addr", bus.imem_addr_o, RESET_PC);

    // Random traffic.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      rnd[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) rnd[31:8] = 24'hFFFFFF;
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
            $urandom_range(0, 49) == 0, rnd);
    end

    // Drain: everything granted since the last redirect must come out.
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 32'h0);
    chk("drain_expected_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_mem_idle", 32'(pend_q.size()), 32'd0);
    chk("enough_outputs", 32'(pops > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
